// File: rtl/melody_player.sv
// Note-table melody player: plays {half_period, beats} entries from a writable
// table onto a piezo pin, with loop, pause/resume and tempo scaling.
module melody_player #(
   parameter int TICK_DIV = 500000,
   parameter int DEPTH    = 64,
   parameter int AW       = 6,
   parameter int HP_W     = 16,
   parameter int DUR_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [HP_W+DUR_W-1:0]   wr_data,
   input  logic [AW-1:0]           last_idx,
   input  logic                    loop_en,
   input  logic [1:0]              tempo_shift,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    pause,
   output logic                    piezo,
   output logic                    playing,
   output logic                    paused,
   output logic [AW-1:0]           note_idx,
   output logic                    done
);

   localparam int EW = HP_W + DUR_W;
   localparam int TW = $clog2(TICK_DIV + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_PLAY  = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;

   logic [EW-1:0]    note_mem [DEPTH];

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    note_idx_q, note_idx_d;
   logic [HP_W-1:0]  hp_q, hp_d;
   logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
   logic [HP_W-1:0]  tone_cnt_q, tone_cnt_d;
   logic [TW-1:0]    beat_cnt_q, beat_cnt_d;
   logic [TW-1:0]    beat_last_q, beat_last_d;
   logic             piezo_q, piezo_d;
   logic             done_q, done_d;
   logic             start_hist_q, start_hist_d;
   logic             stop_hist_q, stop_hist_d;
   logic             pause_hist_q, pause_hist_d;
   logic             armed_q, armed_d;

   logic             start_pulse, stop_pulse, pause_pulse;
   logic [EW-1:0]    fetch_entry;
   logic [HP_W-1:0]  fetch_hp;
   logic [DUR_W-1:0] fetch_dur;
   logic [TW-1:0]    beat_len, beat_last_new;

   always_ff @(posedge clk) begin
      if (wr_en) note_mem[wr_addr] <= wr_data;
   end

   assign fetch_entry = note_mem[note_idx_q];
   assign fetch_hp    = fetch_entry[EW-1:DUR_W];
   assign fetch_dur   = fetch_entry[DUR_W-1:0];

   // History is zero after reset, so the first cycle is masked by armed_q:
   // a button held through reset must not look like a fresh press.
   assign start_pulse = start & ~start_hist_q & armed_q;
   assign stop_pulse  = stop  & ~stop_hist_q  & armed_q;
   assign pause_pulse = pause & ~pause_hist_q & armed_q;

   always_comb begin
      beat_len = TW'(TICK_DIV >> tempo_shift);
      if (beat_len == '0) beat_len = TW'(1);
      beat_last_new = beat_len - TW'(1);
   end

   always_comb begin
      state_d      = state_q;
      note_idx_d   = note_idx_q;
      hp_d         = hp_q;
      dur_cnt_d    = dur_cnt_q;
      tone_cnt_d   = tone_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      beat_last_d  = beat_last_q;
      piezo_d      = piezo_q;
      done_d       = 1'b0;
      start_hist_d = start;
      stop_hist_d  = stop;
      pause_hist_d = pause;
      armed_d      = 1'b1;

      if (stop_pulse) begin
         state_d    = S_IDLE;
         note_idx_d = '0;
         piezo_d    = 1'b0;
      end else if (start_pulse) begin
         if (state_q == S_PAUSE) begin
            state_d = S_PLAY;
         end else begin
            state_d    = S_FETCH;
            note_idx_d = '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               piezo_d    = 1'b0;
               tone_cnt_d = '0;
               beat_cnt_d = '0;
               dur_cnt_d  = '0;
            end
            S_FETCH: begin
               hp_d        = fetch_hp;
               dur_cnt_d   = (fetch_dur == '0) ? DUR_W'(1) : fetch_dur;
               tone_cnt_d  = '0;
               beat_cnt_d  = '0;
               beat_last_d = beat_last_new;
               piezo_d     = 1'b0;
               state_d     = S_PLAY;
            end
            S_PLAY: begin
               if (hp_q == '0) begin
                  tone_cnt_d = '0;
               end else if (tone_cnt_q == hp_q - HP_W'(1)) begin
                  tone_cnt_d = '0;
                  piezo_d    = ~piezo_q;
               end else begin
                  tone_cnt_d = tone_cnt_q + HP_W'(1);
               end

               if (beat_cnt_q == beat_last_q) begin
                  beat_cnt_d  = '0;
                  beat_last_d = beat_last_new;
                  dur_cnt_d   = dur_cnt_q - DUR_W'(1);
                  if (dur_cnt_q == DUR_W'(1)) begin
                     piezo_d    = 1'b0;
                     tone_cnt_d = '0;
                     if (note_idx_q != last_idx) begin
                        note_idx_d = note_idx_q + AW'(1);
                        state_d    = S_FETCH;
                     end else if (loop_en) begin
                        note_idx_d = '0;
                        state_d    = S_FETCH;
                     end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                     end
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + TW'(1);
               end

               // The pause-edge cycle still counts; a note end in that cycle wins.
               if (state_d == S_PLAY && pause_pulse) state_d = S_PAUSE;
            end
            S_PAUSE: begin
               if (pause_pulse) state_d = S_PLAY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         note_idx_q   <= '0;
         hp_q         <= '0;
         dur_cnt_q    <= '0;
         tone_cnt_q   <= '0;
         beat_cnt_q   <= '0;
         beat_last_q  <= '0;
         piezo_q      <= 1'b0;
         done_q       <= 1'b0;
         start_hist_q <= 1'b0;
         stop_hist_q  <= 1'b0;
         pause_hist_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         note_idx_q   <= note_idx_d;
         hp_q         <= hp_d;
         dur_cnt_q    <= dur_cnt_d;
         tone_cnt_q   <= tone_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         beat_last_q  <= beat_last_d;
         piezo_q      <= piezo_d;
         done_q       <= done_d;
         start_hist_q <= start_hist_d;
         stop_hist_q  <= stop_hist_d;
         pause_hist_q <= pause_hist_d;
         armed_q      <= armed_d;
      end
   end

   assign piezo    = piezo_q & (state_q == S_PLAY);
   assign playing  = (state_q == S_FETCH) || (state_q == S_PLAY);
   assign paused   = (state_q == S_PAUSE);
   assign note_idx = note_idx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: directed song scenarios plus random button/table
// traffic, all checked each cycle against an elapsed-time reference model.
module tb_melody_player;

   localparam int TICK  = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int HP_W  = 16;
   localparam int DUR_W = 4;
   localparam int EW    = HP_W + DUR_W;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_PLAY  = 2;
   localparam int M_PAUSE = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [EW-1:0] wr_data = '0;
   logic [AW-1:0] last_idx = '0;
   logic          loop_en = 1'b0;
   logic [1:0]    tempo_shift = 2'd0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic          piezo, playing, paused, done;
   logic [AW-1:0] note_idx;

   always #5 clk = ~clk;

   melody_player #(
      .TICK_DIV(TICK), .DEPTH(DEPTH), .AW(AW), .HP_W(HP_W), .DUR_W(DUR_W)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .last_idx(last_idx), .loop_en(loop_en), .tempo_shift(tempo_shift),
      .start(start), .stop(stop), .pause(pause), .piezo(piezo),
      .playing(playing), .paused(paused), .note_idx(note_idx), .done(done)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: tracks mode, note, beats left, position in the beat and
   // cycles elapsed in the note; tone phase is derived as (elapsed / hp) parity.
   logic [EW-1:0] m_mem [DEPTH];
   int m_mode = M_IDLE, m_idx = 0, m_hp = 0, m_beats = 0, m_pos = 0, m_T = 1, m_el = 0;
   int m_done = 0;
   bit h_start = 0, h_stop = 0, h_pause = 0, m_armed = 0;
   bit sp, tp, pp;

   function automatic int beat_len(input int s);
      return ((TICK >> s) < 1) ? 1 : (TICK >> s);
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_mode = M_IDLE; m_idx = 0; m_done = 0;
         h_start = 0; h_stop = 0; h_pause = 0; m_armed = 0;
      end else begin
         sp = start && !h_start && m_armed;
         tp = stop  && !h_stop  && m_armed;
         pp = pause && !h_pause && m_armed;
         m_done = 0;
         if (tp) begin
            m_mode = M_IDLE; m_idx = 0;
         end else if (sp) begin
            if (m_mode == M_PAUSE) m_mode = M_PLAY;
            else begin m_mode = M_FETCH; m_idx = 0; end
         end else begin
            case (m_mode)
               M_FETCH: begin
                  m_hp    = int'(m_mem[m_idx][EW-1:DUR_W]);
                  m_beats = int'(m_mem[m_idx][DUR_W-1:0]);
                  if (m_beats == 0) m_beats = 1;
                  m_pos = 0; m_el = 0; m_T = beat_len(int'(tempo_shift));
                  m_mode = M_PLAY;
               end
               M_PLAY: begin
                  m_el++; m_pos++;
                  if (m_pos == m_T) begin
                     m_pos = 0; m_beats--; m_T = beat_len(int'(tempo_shift));
                  end
                  if (m_beats == 0) begin
                     if (m_idx != int'(last_idx)) begin m_idx++; m_mode = M_FETCH; end
                     else if (loop_en) begin m_idx = 0; m_mode = M_FETCH; end
                     else begin m_done = 1; m_mode = M_IDLE; end
                  end else if (pp) m_mode = M_PAUSE;
               end
               M_PAUSE: if (pp) m_mode = M_PLAY;
               default: ;
            endcase
         end
         h_start = start; h_stop = stop; h_pause = pause; m_armed = 1;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
   end

   task automatic check_all();
      int exp_piezo;
      exp_piezo = (m_mode == M_PLAY && m_hp != 0) ? ((m_el / m_hp) % 2) : 0;
      check_eq("piezo", piezo, exp_piezo);
      check_eq("playing", playing, (m_mode == M_FETCH || m_mode == M_PLAY) ? 1 : 0);
      check_eq("paused", paused, (m_mode == M_PAUSE) ? 1 : 0);
      check_eq("note_idx", note_idx, m_idx);
      check_eq("done", done, m_done);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic wr_entry(input int a, input int hp, input int dur);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = {16'(hp), 4'(dur)};
      tick();
      wr_en = 1'b0;
   endtask

   // Leaves the DUT in its FETCH cycle (cycle 0 of the song).
   task automatic press_start();
      start = 1'b0; tick();
      start = 1'b1; tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int done_at, cnt, ndone, idx1_at, idx2_at, wrap_at, pcnt, phi, hi0, hi1;
      logic prev;
      bit seen2;

      @(negedge clk);
      rst = 1'b0;
      tick(); tick();
      check_eq("rst_playing", playing, 0);
      check_eq("rst_piezo", piezo, 0);
      check_eq("rst_note_idx", note_idx, 0);
      rst = 1'b1;
      tick();
      for (int a = 0; a < DEPTH; a++) wr_entry(a, $urandom_range(0, 7), $urandom_range(0, 3));

      // Single note: hp=3, two beats of 8.
      wr_entry(0, 3, 2); last_idx = '0; loop_en = 1'b0; tempo_shift = 2'd0;
      press_start();
      check_eq("s1_fetch", playing, 1);
      done_at = -1; cnt = 0; prev = piezo;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (playing === 1'b1 && piezo !== prev) cnt++;
         prev = piezo;
         if (done === 1'b1) begin done_at = k; break; end
      end
      check_eq("s1_done_cycle", done_at, 17);
      check_eq("s1_toggles", cnt, 5);
      check_eq("s1_idle", playing, 0);

      // Three notes with a rest in the middle.
      wr_entry(0, 2, 1); wr_entry(1, 0, 1); wr_entry(2, 4, 1); last_idx = AW'(2);
      press_start();
      idx1_at = -1; idx2_at = -1; done_at = -1; ndone = 0; cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (note_idx === AW'(1) && idx1_at < 0) idx1_at = k;
         if (note_idx === AW'(2) && idx2_at < 0) idx2_at = k;
         if (note_idx === AW'(1) && piezo === 1'b1) cnt++;
         if (done === 1'b1) begin ndone++; done_at = k; end
      end
      check_eq("s2_idx1_cycle", idx1_at, 9);
      check_eq("s2_idx2_cycle", idx2_at, 18);
      check_eq("s2_done_cycle", done_at, 27);
      check_eq("s2_done_count", ndone, 1);
      check_eq("s2_rest_silent", cnt, 0);

      // Loop at double tempo, then stop.
      loop_en = 1'b1; tempo_shift = 2'd1;
      press_start();
      seen2 = 0; wrap_at = -1; ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (note_idx === AW'(2)) seen2 = 1;
         if (seen2 && note_idx === '0 && wrap_at < 0) wrap_at = k;
         if (done === 1'b1) ndone++;
      end
      check_eq("s3_wrap_cycle", wrap_at, 15);
      check_eq("s3_no_done", ndone, 0);
      stop = 1'b1; tick();
      check_eq("s3_stop_idle", playing, 0);
      check_eq("s3_stop_idx", note_idx, 0);
      stop = 1'b0; loop_en = 1'b0; tempo_shift = 2'd0; tick();

      // Pause at cycle 6 for 20 held cycles, resume edge at cycle 27.
      wr_entry(0, 3, 2); last_idx = '0;
      press_start();
      done_at = -1; pcnt = 0; phi = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (paused === 1'b1) pcnt++;
         if (paused === 1'b1 && piezo !== 1'b0) phi++;
         if (done === 1'b1) begin done_at = k; break; end
         pause = ((k >= 6 && k < 26) || k == 27);
      end
      pause = 1'b0;
      check_eq("s4_done_cycle", done_at, 38);
      check_eq("s4_pause_cycles", pcnt, 21);
      check_eq("s4_pause_silent", phi, 0);

      // Same-cycle start and stop while idle.
      start = 1'b0; stop = 1'b0; tick();
      start = 1'b1; stop = 1'b1; tick();
      check_eq("prio_stop_start", playing, 0);
      start = 1'b0; stop = 1'b0; tick();

      // Reset mid-note with start held.
      press_start();
      repeat (5) tick();
      rst = 1'b0; tick();
      check_eq("rstm_playing", playing, 0);
      check_eq("rstm_piezo", piezo, 0);
      check_eq("rstm_done", done, 0);
      rst = 1'b1;
      repeat (4) tick();
      check_eq("rstm_held_start", playing, 0);
      press_start();
      check_eq("rstm_replay", playing, 1);
      stop = 1'b1; tick(); stop = 1'b0; tick();

      // Table rewrites during note 0.
      wr_entry(0, 3, 2); wr_entry(1, 5, 1); last_idx = AW'(1);
      press_start();
      hi0 = 0; hi1 = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (piezo === 1'b1 && note_idx === '0) hi0++;
         if (piezo === 1'b1 && note_idx === AW'(1)) hi1++;
         if (done === 1'b1) break;
         wr_en = (k == 3 || k == 4);
         wr_addr = (k == 3) ? AW'(1) : '0;
         wr_data = (k == 3) ? {16'd2, 4'd1} : {16'd5, 4'd2};
      end
      wr_en = 1'b0;
      check_eq("s6_note0_unchanged", hi0, 7);
      check_eq("s6_note1_new_hp", hi1, 4);
      press_start();
      hi0 = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (piezo === 1'b1 && note_idx === '0) hi0++;
      end
      check_eq("s6_note0_refetched", hi0, 6);
      stop = 1'b1; tick(); stop = 1'b0; start = 1'b0; tick();

      // Random traffic.
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 39) == 0) start = ~start;
         if ($urandom_range(0, 79) == 0) stop = ~stop;
         if ($urandom_range(0, 29) == 0) pause = ~pause;
         wr_en   = ($urandom_range(0, 19) == 0);
         wr_addr = AW'($urandom_range(0, 7));
         wr_data = {16'($urandom_range(0, 6)), 4'($urandom_range(0, 3))};
         if (m_mode == M_IDLE && $urandom_range(0, 9) == 0) begin
            last_idx = AW'($urandom_range(0, 7));
            loop_en  = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 49) == 0) tempo_shift = 2'($urandom_range(0, 3));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
